spi_register_sequencer: RTL and testbench
=========================================

# spi_register_sequencer

Table-driven SPI configuration sequencer that walks an external register table after a start pulse and programs up to NUM_SLAVES sensor/PHY devices. It supports plain writes, write-with-readback-verify with bounded retries, and timed delays. It reports done/error status with the failing table index. It sits between the system reset/control logic and the image-sensor SPI pins, replacing fixed hard-coded configuration sequences.

## Interface
- NUM_SLAVES, 2: number of chip selects; SLV_W = max(1, clog2(NUM_SLAVES)).
- ADDR_W, 8: register address field width. The MSB is the R/W flag: 1 = write, 0 = read.
- DATA_W, 8: register data width. FRAME_W = ADDR_W + DATA_W.
- MAX_ENTRIES, 16: table depth. IDX_W = clog2(MAX_ENTRIES).
- CLK_DIV, 4: clk cycles per SCLK half-period, ≥1.
- GAP_CYCLES, 8: ss_n high time between frames, ≥1.
- MAX_RETRIES, 3: extra write+verify attempts after the first failure.
- DELAY_UNIT, 256: clk cycles per delay count.
- clk, in, 1: clock.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: one-cycle request. Accepted only in IDLE, DONE or FAIL.
- table_index, out, IDX_W: entry address. The table is a combinational ROM.
- table_entry, in, 2+SLV_W+FRAME_W: entry fields {op[1:0], slave, addr, data}.
- busy, out, 1: high from start acceptance until DONE/FAIL.
- done, out, 1: level. High in DONE until the next accepted start.
- error, out, 1: level. High in FAIL until the next accepted start.
- error_index, out, IDX_W: entry index that exhausted its retries.
- miso, in, 1: SPI data in.
- mosi, out, 1: SPI data out.
- sclk, out, 1: SPI clock, mode 0 (idle low).
- ss_n, out, NUM_SLAVES: active-low chip selects. At most one is low.

## Operation
- op encoding:
  - 00 END: finish, go to DONE.
  - 01 WRITE: send {addr|MSB=1, data}.
  - 10 WRITE_VERIFY: send a write frame, then a read frame {addr with MSB=0, DATA_W zeros}. Capture the last DATA_W miso bits and compare with data.
  - 11 DELAY: wait data×DELAY_UNIT cycles. data=0 means zero wait.
- States: IDLE → FETCH → (XFER_WR → GAP → [XFER_RD → GAP → CHECK]) | WAIT → FETCH … → DONE | FAIL.
- FETCH samples table_entry for the current table_index.
- table_index increments on leaving GAP, CHECK-pass or WAIT.
- Reaching index MAX_ENTRIES−1 without an END entry: after that entry completes, go to DONE.
- CHECK mismatch with retry_cnt < MAX_RETRIES: retry_cnt++, return to XFER_WR for the same entry.
- CHECK mismatch with retry_cnt = MAX_RETRIES: latch error_index, go to FAIL. No further frames are sent.
- retry_cnt clears on each new entry.
- A slave field ≥ NUM_SLAVES is treated as a failure of that entry: go to FAIL with no frame sent.
- start in DONE/FAIL restarts from index 0 and clears done/error.
- start while busy is ignored.
- Reset values: table_index=0, busy=0, done=0, error=0, error_index=0, mosi=0, sclk=0, ss_n=all 1, retry_cnt=0, state IDLE.
- Reset mid-frame: ss_n all high and sclk low on the first clk edge with reset_n low. No partial-frame completion.

## Timing
- start sampled at edge 0 → busy=1 and FETCH at edge 1 → ss_n[slave] low at edge 2. t0 is the edge where ss_n goes low.
- At t0, mosi = frame MSB.
- Bit k (k=0 is the MSB): sclk rises at t0+(2k+1)·CLK_DIV, where miso is sampled. sclk falls at t0+(2k+2)·CLK_DIV, where mosi shifts.
- ss_n rises at t0+(2·FRAME_W+1)·CLK_DIV, then stays high for exactly GAP_CYCLES cycles before the next fetch or frame.
- WRITE entry cost: 1 + (2·FRAME_W+1)·CLK_DIV + GAP_CYCLES cycles.
- CHECK takes 1 cycle. DONE/FAIL is entered 1 cycle after the last GAP/CHECK; busy falls on the same edge.

## Structure
- Shared package: op codes, state encoding, entry field offset localparams.
- Sub-module spi_frame_engine: FRAME_W shift register, CLK_DIV prescaler, ss_n decode, go/ready handshake, rx_data output.
- The sequencer contains the FSM, index, retry and delay counters.

## Test plan
- Defaults, table {WRITE s0 0x93/0x05, WRITE s1 0xB2/0x02, END} → two 16-bit frames 0x9305 on ss_n[0] and 0xB202 on ss_n[1], edge-accurate; then done=1, busy=0.
- WRITE_VERIFY 0xC0/0x03, slave model echoes 0x03 → write frame 0xC003, read frame 0x4000, then next entry; no error.
- WRITE_VERIFY, model always returns 0x00 → 4 write/read pairs, then error=1, error_index=0, ss_n stays high.
- DELAY data=2, DELAY_UNIT=256 → ss_n high gap between neighbouring frames = 512 + GAP_CYCLES + 1 cycles.
- Reset asserted at bit 5 of a frame → next edge ss_n=2'b11, sclk=0, busy=0; a new start reruns from index 0.
- Full table of 16 WRITEs with no END → 16 frames, then done; start pulses while busy have no effect.

Source files
------------

// File: rtl/spi_register_sequencer_pkg.sv
// Shared definitions for the SPI register sequencer.
//   - op_e    : table entry operation codes
//   - state_e : sequencer FSM state encoding
//   - helper functions giving derived widths and table entry field offsets
//     (entry layout, MSB to LSB: {op[1:0], slave, addr, data})
package spi_register_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_END     = 2'b00,
        OP_WRITE   = 2'b01,
        OP_WVERIFY = 2'b10,
        OP_DELAY   = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_XFER_WR = 4'd2,
        ST_GAP     = 4'd3,
        ST_XFER_RD = 4'd4,
        ST_CHECK   = 4'd5,
        ST_WAIT    = 4'd6,
        ST_DONE    = 4'd7,
        ST_FAIL    = 4'd8
    } state_e;

    localparam int ENT_DATA_LSB = 0;

    // Width able to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ent_addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int ent_slave_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int ent_op_lsb(input int slv_w, input int addr_w, input int data_w);
        return slv_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_register_sequencer_frame_engine.sv
// spi_frame_engine: shifts out one SPI mode-0 frame (MSB first) while
// shifting in miso, then releases the chip select.
//   clk, reset_n : clock, synchronous active-low reset
//   i_go         : start a frame (taken only when o_ready is high)
//   i_frame      : FRAME_W bits to transmit
//   i_slave      : chip select to drive low for this frame
//   i_miso       : serial data in, sampled on sclk rising edges
//   o_ready      : engine idle
//   o_last       : high in the cycle whose closing edge releases ss_n
//   o_rx_data    : last DATA_W bits received
//   o_mosi, o_sclk, o_ss_n : SPI pins
module spi_frame_engine
    import spi_register_sequencer_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   i_go,
    input  logic [ADDR_W+DATA_W-1:0]               i_frame,
    input  logic [clog2_min1(NUM_SLAVES)-1:0]      i_slave,
    input  logic                                   i_miso,
    output logic                                   o_ready,
    output logic                                   o_last,
    output logic [DATA_W-1:0]                      o_rx_data,
    output logic                                   o_mosi,
    output logic                                   o_sclk,
    output logic [NUM_SLAVES-1:0]                  o_ss_n
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int SLV_W   = clog2_min1(NUM_SLAVES);
    localparam int DIV_W   = clog2_min1(CLK_DIV);
    localparam int HALF_W  = $clog2(2 * FRAME_W + 1);
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * FRAME_W);

    logic                  r_active;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [HALF_W-1:0]     r_half_cnt;
    logic                  r_sclk;
    logic [NUM_SLAVES-1:0] r_ss_n;
    logic [FRAME_W-1:0]    r_shift;
    logic [DATA_W-1:0]     r_rx;

    logic                  w_load;
    logic                  w_tick;
    logic                  w_last;
    logic [NUM_SLAVES-1:0] w_ss_sel;

    assign w_load = i_go && !r_active;
    assign w_tick = r_active && (r_div_cnt == DIV_MAX);
    // Half-periods are numbered from 1; the one after the final sclk fall
    // (number 2*FRAME_W+1) closes the frame.
    assign w_last = w_tick && (r_half_cnt == LAST_HALF);

    always_comb begin
        w_ss_sel = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_ss_sel[i] = (i_slave != SLV_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active   <= 1'b0;
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
            r_sclk     <= 1'b0;
            r_ss_n     <= '1;
        end else if (w_load) begin
            r_active   <= 1'b1;
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
            r_sclk     <= 1'b0;
            r_ss_n     <= w_ss_sel;
        end else if (w_tick) begin
            r_div_cnt  <= '0;
            r_half_cnt <= r_half_cnt + HALF_W'(1);
            if (w_last) begin
                r_active <= 1'b0;
                r_ss_n   <= '1;
            end else begin
                // Even count so far means the next edge is a rising one.
                r_sclk <= !r_half_cnt[0];
            end
        end else if (r_active) begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_shift <= i_frame;
        end else if (w_tick && !w_last) begin
            if (!r_half_cnt[0]) begin
                r_rx <= {r_rx[DATA_W-2:0], i_miso};
            end else begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign o_ready   = !r_active;
    assign o_last    = w_last;
    assign o_rx_data = r_rx;
    assign o_mosi    = r_active && r_shift[FRAME_W-1];
    assign o_sclk    = r_sclk;
    assign o_ss_n    = r_ss_n;

endmodule

// File: rtl/spi_register_sequencer.sv
// spi_register_sequencer: walks an external register table after a start
// pulse and programs SPI slaves with writes, verified writes and delays.
//   clk, reset_n  : clock, synchronous active-low reset
//   start         : one-cycle request, honoured in IDLE/DONE/FAIL
//   table_index   : current table address (combinational ROM outside)
//   table_entry   : {op[1:0], slave, addr, data} for table_index
//   busy          : sequence in progress
//   done, error   : completion levels, cleared by the next accepted start
//   error_index   : entry that failed
//   miso, mosi, sclk, ss_n : SPI pins (mode 0)
module spi_register_sequencer
    import spi_register_sequencer_pkg::*;
#(
    parameter int NUM_SLAVES  = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MAX_ENTRIES = 16,
    parameter int CLK_DIV     = 4,
    parameter int GAP_CYCLES  = 8,
    parameter int MAX_RETRIES = 3,
    parameter int DELAY_UNIT  = 256
) (
    input  logic                                                   clk,
    input  logic                                                   reset_n,
    input  logic                                                   start,
    output logic [$clog2(MAX_ENTRIES)-1:0]                         table_index,
    input  logic [2+clog2_min1(NUM_SLAVES)+ADDR_W+DATA_W-1:0]      table_entry,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   error,
    output logic [$clog2(MAX_ENTRIES)-1:0]                         error_index,
    input  logic                                                   miso,
    output logic                                                   mosi,
    output logic                                                   sclk,
    output logic [NUM_SLAVES-1:0]                                  ss_n
);

    localparam int SLV_W    = clog2_min1(NUM_SLAVES);
    localparam int FRAME_W  = ADDR_W + DATA_W;
    localparam int IDX_W    = $clog2(MAX_ENTRIES);
    localparam int GAP_W    = clog2_min1(GAP_CYCLES);
    localparam int RTRY_W   = clog2_min1(MAX_RETRIES + 1);
    localparam int WAIT_W   = DATA_W + $clog2(DELAY_UNIT) + 1;
    localparam int ADDR_LSB = ent_addr_lsb(DATA_W);
    localparam int SLV_LSB  = ent_slave_lsb(ADDR_W, DATA_W);
    localparam int OP_LSB   = ent_op_lsb(SLV_W, ADDR_W, DATA_W);
    localparam logic [ADDR_W-1:0] ADDR_RW_MASK = {1'b1, {(ADDR_W-1){1'b0}}};

    state_e              r_state;
    state_e              w_next_state;
    logic                r_start_q;
    logic [IDX_W-1:0]    r_index;
    logic [IDX_W-1:0]    r_err_index;
    logic [RTRY_W-1:0]   r_retry_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_rd_phase;
    op_e                 r_entry_op;
    logic [SLV_W-1:0]    r_entry_slv;
    logic [ADDR_W-1:0]   r_entry_addr;
    logic [DATA_W-1:0]   r_entry_data;

    op_e                 w_live_op;
    logic [SLV_W-1:0]    w_live_slv;
    logic [ADDR_W-1:0]   w_live_addr;
    logic [DATA_W-1:0]   w_live_data;
    logic                w_slave_ok;
    logic [WAIT_W-1:0]   w_delay_len;
    logic                w_accept;
    logic                w_last_idx;
    logic                w_gap_last;
    logic                w_match;
    logic                w_retry_left;
    logic                w_adv;
    logic                w_go;
    logic [FRAME_W-1:0]  w_frame;
    logic [SLV_W-1:0]    w_frame_slv;
    logic                w_eng_ready;
    logic                w_eng_last;
    logic [DATA_W-1:0]   w_rx_data;
    state_e              w_after_entry;

    assign w_live_op    = op_e'(table_entry[OP_LSB +: 2]);
    assign w_live_slv   = table_entry[SLV_LSB +: SLV_W];
    assign w_live_addr  = table_entry[ADDR_LSB +: ADDR_W];
    assign w_live_data  = table_entry[ENT_DATA_LSB +: DATA_W];
    // Widened by one bit so the range check stays meaningful when
    // NUM_SLAVES is a power of two.
    assign w_slave_ok   = {1'b0, w_live_slv} < (SLV_W+1)'(NUM_SLAVES);
    assign w_delay_len  = WAIT_W'(w_live_data) * WAIT_W'(DELAY_UNIT);
    assign w_accept     = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL);
    assign w_last_idx   = (r_index == IDX_W'(MAX_ENTRIES - 1));
    assign w_gap_last   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign w_match      = (w_rx_data == r_entry_data);
    assign w_retry_left = (r_retry_cnt < RTRY_W'(MAX_RETRIES));
    // The last table slot finishes the sequence even without an END entry.
    assign w_after_entry = w_last_idx ? ST_DONE : ST_FETCH;
    assign w_adv = (w_next_state == ST_FETCH) && !w_accept;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (r_start_q) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                case (w_live_op)
                    OP_END:   w_next_state = ST_DONE;
                    OP_DELAY: begin
                        // FETCH already accounts for one cycle of the delay.
                        if (w_delay_len <= WAIT_W'(1)) w_next_state = w_after_entry;
                        else                           w_next_state = ST_WAIT;
                    end
                    default:  w_next_state = w_slave_ok ? ST_XFER_WR : ST_FAIL;
                endcase
            end
            ST_XFER_WR, ST_XFER_RD: begin
                if (w_eng_last) w_next_state = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_last) begin
                    if (r_rd_phase)                   w_next_state = ST_CHECK;
                    else if (r_entry_op == OP_WVERIFY) w_next_state = ST_XFER_RD;
                    else                              w_next_state = w_after_entry;
                end
            end
            ST_CHECK: begin
                if (w_match)           w_next_state = w_after_entry;
                else if (w_retry_left) w_next_state = ST_XFER_WR;
                else                   w_next_state = ST_FAIL;
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) w_next_state = w_after_entry;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: status levels and frame launch
    always_comb begin
        busy        = !w_accept;
        done        = (r_state == ST_DONE);
        error       = (r_state == ST_FAIL);
        w_go        = w_eng_ready &&
                      (((w_next_state == ST_XFER_WR) && (r_state != ST_XFER_WR)) ||
                       ((w_next_state == ST_XFER_RD) && (r_state != ST_XFER_RD)));
        w_frame     = {r_entry_addr | ADDR_RW_MASK, r_entry_data};
        w_frame_slv = r_entry_slv;
        if (r_state == ST_FETCH) begin
            w_frame     = {w_live_addr | ADDR_RW_MASK, w_live_data};
            w_frame_slv = w_live_slv;
        end else if (r_state == ST_GAP) begin
            w_frame = {r_entry_addr & ~ADDR_RW_MASK, {DATA_W{1'b0}}};
        end
    end

    // Control counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_start_q   <= 1'b0;
            r_index     <= '0;
            r_err_index <= '0;
            r_retry_cnt <= '0;
            r_gap_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_rd_phase  <= 1'b0;
        end else begin
            r_start_q <= start && w_accept;

            if (w_accept && r_start_q) r_index <= '0;
            else if (w_adv)            r_index <= r_index + IDX_W'(1);

            if ((w_next_state == ST_FAIL) && (r_state != ST_FAIL)) r_err_index <= r_index;

            if (r_state == ST_FETCH)
                r_retry_cnt <= '0;
            else if ((r_state == ST_CHECK) && (w_next_state == ST_XFER_WR))
                r_retry_cnt <= r_retry_cnt + RTRY_W'(1);

            if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            else                   r_gap_cnt <= '0;

            if (r_state == ST_FETCH)     r_wait_cnt <= w_delay_len - WAIT_W'(2);
            else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt - WAIT_W'(1);

            if (w_next_state == ST_XFER_RD)      r_rd_phase <= 1'b1;
            else if (w_next_state == ST_XFER_WR) r_rd_phase <= 1'b0;
        end
    end

    // Entry capture
    always_ff @(posedge clk) begin
        if (r_state == ST_FETCH) begin
            r_entry_op   <= w_live_op;
            r_entry_slv  <= w_live_slv;
            r_entry_addr <= w_live_addr;
            r_entry_data <= w_live_data;
        end
    end

    assign table_index = r_index;
    assign error_index = r_err_index;

    spi_frame_engine #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CLK_DIV    (CLK_DIV)
    ) u_frame_engine (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_go      (w_go),
        .i_frame   (w_frame),
        .i_slave   (w_frame_slv),
        .i_miso    (miso),
        .o_ready   (w_eng_ready),
        .o_last    (w_eng_last),
        .o_rx_data (w_rx_data),
        .o_mosi    (mosi),
        .o_sclk    (sclk),
        .o_ss_n    (ss_n)
    );

endmodule

// File: tb/tb_spi_register_sequencer.sv
module tb_spi_register_sequencer;

    localparam int CD   = 4;
    localparam int GAP  = 8;
    localparam int FLEN = (2 * 16 + 1) * CD;

    typedef struct {
        logic [15:0] data;
        int          slv;
        int          t0;
        int          t1;
        bit          ok;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  table_index;
    logic [18:0] table_entry;
    logic        busy, done, error;
    logic [3:0]  error_index;
    logic        miso = 1'b0;
    logic        mosi, sclk;
    logic [1:0]  ss_n;

    logic [18:0] tbl [16];
    assign table_entry = tbl[table_index];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    frame_t      frames[$];
    frame_t      cur;
    bit          in_frame = 0;
    int          nbits = 0;
    logic        mosi0 = 1'b0;
    logic [1:0]  prev_ss = 2'b11;
    logic        prev_sclk = 1'b0;
    int          ss_bad = 0;
    logic [15:0] reply16 = 16'h0000;

    spi_register_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .table_index (table_index),
        .table_entry (table_entry),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_index (error_index),
        .miso        (miso),
        .mosi        (mosi),
        .sclk        (sclk),
        .ss_n        (ss_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // SPI slave model: records frames with edge timing, drives miso from reply16.
    always @(negedge clk) begin
        if (ss_n == 2'b00) ss_bad++;
        if (!in_frame && prev_ss == 2'b11 && ss_n != 2'b11) begin
            in_frame = 1;
            cur.t0   = cyc;
            cur.slv  = (ss_n == 2'b10) ? 0 : 1;
            cur.data = 16'h0;
            cur.ok   = 1;
            nbits    = 0;
            mosi0    = mosi;
        end else if (in_frame) begin
            if (!prev_sclk && sclk) begin
                cur.data = {cur.data[14:0], mosi};
                if (cyc - cur.t0 != (2 * nbits + 1) * CD) cur.ok = 0;
                nbits++;
            end
            if (prev_sclk && !sclk) begin
                if (cyc - cur.t0 != 2 * nbits * CD) cur.ok = 0;
            end
            if (ss_n == 2'b11) begin
                in_frame = 0;
                cur.t1   = cyc;
                if (cyc - cur.t0 != FLEN || nbits != 16 || mosi0 != cur.data[15]) cur.ok = 0;
                frames.push_back(cur);
            end
        end
        miso      = (in_frame && nbits < 16) ? reply16[15 - nbits] : 1'b0;
        prev_ss   = ss_n;
        prev_sclk = sclk;
    end

    function automatic logic [18:0] mk(input logic [1:0] op, input logic slv,
                                       input logic [7:0] addr, input logic [7:0] data);
        return {op, slv, addr, data};
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 16; i++) tbl[i] = 19'h0;
    endtask

    task automatic pulse_start(output int e0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget, output int t_end);
        bit seen;
        seen  = 0;
        t_end = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done || error) begin
                seen  = 1;
                t_end = cyc;
            end
        end
        chk({tag, "_finished"}, 32'(seen), 32'd1);
    endtask

    task automatic chk_frame(input string tag, input int i, input logic [15:0] data, input int slv);
        bit present;
        present = (frames.size() > i);
        chk({tag, "_present"}, 32'(present), 32'd1);
        if (present) begin
            chk({tag, "_data"}, 32'(frames[i].data), 32'(data));
            chk({tag, "_slave"}, 32'(frames[i].slv), 32'(slv));
            chk({tag, "_timing"}, 32'(frames[i].ok), 32'd1);
        end
    endtask

    function automatic int fr_t0(input int i);
        return (frames.size() > i) ? frames[i].t0 : -1;
    endfunction

    function automatic int fr_t1(input int i);
        return (frames.size() > i) ? frames[i].t1 : -1;
    endfunction

    initial begin
        int e0, t_end, t0, nfr;
        clear_table();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_ss_n", 32'(ss_n), 32'h3);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_index", 32'(table_index), 0);
        chk("rst_err_index", 32'(error_index), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two plain writes then END
        tbl[0] = mk(2'b01, 1'b0, 8'h93, 8'h05);
        tbl[1] = mk(2'b01, 1'b1, 8'hB2, 8'h02);
        frames.delete();
        pulse_start(e0);
        chk("t1_busy_edge0", 32'(busy), 0);
        @(negedge clk);
        chk("t1_busy_edge1", 32'(busy), 1);
        wait_end("t1", 2000, t_end);
        chk("t1_nframes", 32'(frames.size()), 2);
        chk_frame("t1_f0", 0, 16'h9305, 0);
        chk_frame("t1_f1", 1, 16'hB202, 1);
        chk("t1_f0_t0", 32'(fr_t0(0)), 32'(e0 + 2));
        chk("t1_f1_t0", 32'(fr_t0(1)), 32'(fr_t1(0) + GAP + 1));
        chk("t1_done_edge", 32'(t_end), 32'(fr_t1(1) + GAP + 1));
        chk("t1_done", 32'(done), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_error", 32'(error), 0);

        // Verified write with echoing slave, then a write
        clear_table();
        tbl[0] = mk(2'b10, 1'b0, 8'hC0, 8'h03);
        tbl[1] = mk(2'b01, 1'b1, 8'h11, 8'h22);
        reply16 = 16'h0003;
        frames.delete();
        pulse_start(e0);
        @(negedge clk);
        chk("t2_done_cleared", 32'(done), 0);
        wait_end("t2", 3000, t_end);
        chk("t2_nframes", 32'(frames.size()), 3);
        chk_frame("t2_wr", 0, 16'hC003, 0);
        chk_frame("t2_rd", 1, 16'h4000, 0);
        chk_frame("t2_next", 2, 16'h9122, 1);
        chk("t2_rd_t0", 32'(fr_t0(1)), 32'(fr_t1(0) + GAP));
        chk("t2_next_t0", 32'(fr_t0(2)), 32'(fr_t1(1) + GAP + 2));
        chk("t2_done", 32'(done), 1);
        chk("t2_error", 32'(error), 0);

        // Verified write that never matches: retries exhausted at index 1
        clear_table();
        tbl[0] = mk(2'b01, 1'b1, 8'h85, 8'h5A);
        tbl[1] = mk(2'b10, 1'b0, 8'hC0, 8'h03);
        reply16 = 16'h0000;
        frames.delete();
        pulse_start(e0);
        wait_end("t3", 4000, t_end);
        chk("t3_error", 32'(error), 1);
        chk("t3_done", 32'(done), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_err_index", 32'(error_index), 1);
        chk("t3_nframes", 32'(frames.size()), 9);
        chk_frame("t3_f0", 0, 16'h855A, 1);
        for (int k = 0; k < 4; k++) begin
            chk_frame($sformatf("t3_wr%0d", k), 1 + 2 * k, 16'hC003, 0);
            chk_frame($sformatf("t3_rd%0d", k), 2 + 2 * k, 16'h4000, 0);
        end
        chk("t3_retry_t0", 32'(fr_t0(3)), 32'(fr_t1(2) + GAP + 1));
        chk("t3_fail_edge", 32'(t_end), 32'(fr_t1(8) + GAP + 1));
        repeat (300) @(negedge clk);
        chk("t3_no_more_frames", 32'(frames.size()), 9);
        chk("t3_ss_idle", 32'(ss_n), 32'h3);

        // Delay entry between two writes
        clear_table();
        tbl[0] = mk(2'b01, 1'b0, 8'h81, 8'h11);
        tbl[1] = mk(2'b11, 1'b0, 8'h00, 8'h02);
        tbl[2] = mk(2'b01, 1'b1, 8'h02, 8'h22);
        frames.delete();
        pulse_start(e0);
        @(negedge clk);
        chk("t4_error_cleared", 32'(error), 0);
        wait_end("t4", 3000, t_end);
        chk("t4_nframes", 32'(frames.size()), 2);
        chk_frame("t4_f0", 0, 16'h8111, 0);
        chk_frame("t4_f1", 1, 16'h8222, 1);
        chk("t4_delay_gap", 32'(fr_t0(1) - fr_t1(0)), 32'(512 + GAP + 1));
        chk("t4_done", 32'(done), 1);

        // Reset during bit 5 of a frame, then restart
        clear_table();
        tbl[0] = mk(2'b01, 1'b0, 8'hA5, 8'h5A);
        tbl[1] = mk(2'b01, 1'b1, 8'h3C, 8'hC3);
        frames.delete();
        pulse_start(e0);
        t0 = -1;
        for (int i = 0; i < 20 && t0 < 0; i++) begin
            @(negedge clk);
            if (ss_n != 2'b11) t0 = cyc;
        end
        chk("t5_frame_started", 32'(t0 >= 0), 1);
        repeat (45) @(negedge clk);
        chk("t5_pre_sclk", 32'(sclk), 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_ss_n", 32'(ss_n), 32'h3);
        chk("t5_rst_sclk", 32'(sclk), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_mosi", 32'(mosi), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        frames.delete();
        pulse_start(e0);
        wait_end("t5", 2000, t_end);
        chk("t5_nframes", 32'(frames.size()), 2);
        chk_frame("t5_f0", 0, 16'hA55A, 0);
        chk_frame("t5_f1", 1, 16'hBCC3, 1);
        chk("t5_f0_t0", 32'(fr_t0(0)), 32'(e0 + 2));

        // Sixteen writes with no END, start pulses while busy
        clear_table();
        for (int i = 0; i < 16; i++)
            tbl[i] = mk(2'b01, 1'(i % 2), 8'(8'h40 + i), 8'(i * 7 + 3));
        frames.delete();
        pulse_start(e0);
        repeat (500) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy_after_start", 32'(busy), 1);
        repeat (700) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("t6", 4000, t_end);
        nfr = frames.size();
        chk("t6_nframes", 32'(nfr), 16);
        for (int i = 0; i < 16; i++)
            chk_frame($sformatf("t6_f%0d", i), i,
                      {8'(8'hC0 + i), 8'(i * 7 + 3)}, i % 2);
        chk("t6_done", 32'(done), 1);
        chk("t6_error", 32'(error), 0);
        repeat (200) @(negedge clk);
        chk("t6_no_restart", 32'(frames.size()), 16);

        chk("ss_onehot", 32'(ss_bad), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
